// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch requester, the data requester and the
// unified RAM port that mem_arbiter sits between.
//   fetch : iREN, iaddr -> iwait, iload
//   data  : dREN, dWEN, daddr, dstore -> dwait, dload
//   ram   : ramREN, ramWEN, ramaddr, ramstore -> ramload, ramready
// The master modport is the surrounding system (CPU datapath plus RAM);
// the slave modport is the arbiter itself.
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;

  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between instruction fetch and data access.
// Data wins by default; a registered grant drives the RAM from the registered
// request copy until ramready, then one IDLE cycle follows every access.
//   CLK, RST : clock (rising edge), asynchronous active-high reset
//   bus      : mem_arbiter_if.slave (fetch, data and RAM signal groups)
//   STARVE_MAX : data grants tolerated while fetch waits (1..15)
// Optional feature: define ARB_STARVE_GUARD_EN to enable the fetch
// starvation guard; without it data has strict priority.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic          CLK,
  input logic          RST,
  mem_arbiter_if.slave bus
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("mem_arbiter: STARVE_MAX must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

  state_t      state, next_state;
  logic        grant_i, grant_d;
  logic        guard_trip;
  logic        dreq;
  logic        busy;
  logic        acc_ren, acc_wen;
  logic [31:0] acc_addr, acc_store;

  assign dreq = bus.dREN | bus.dWEN;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve;

  assign guard_trip = (starve == 4'(STARVE_MAX)) && bus.iREN;

  // Counts data grants won while fetch was waiting; any fetch grant or an
  // IDLE cycle without a fetch request starts the count over.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      starve <= '0;
    end else if (state == IDLE) begin
      if (grant_i || !bus.iREN) begin
        starve <= '0;
      end else if (grant_d && starve != 4'(STARVE_MAX)) begin
        starve <= starve + 4'd1;
      end
    end
  end
`else
  assign guard_trip = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (dreq && !guard_trip) begin
          next_state = DACC;
          grant_d    = 1'b1;
        end else if (bus.iREN) begin
          next_state = IACC;
          grant_i    = 1'b1;
        end
      end
      IACC, DACC: begin
        if (bus.ramready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Request copy captured at grant; a requester may drop or change its lines
  // mid-access without disturbing the RAM transaction. dWEN beats dREN.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_ren   <= 1'b0;
      acc_wen   <= 1'b0;
      acc_addr  <= '0;
      acc_store <= '0;
    end else if (grant_d) begin
      acc_ren   <= ~bus.dWEN;
      acc_wen   <= bus.dWEN;
      acc_addr  <= bus.daddr;
      acc_store <= bus.dstore;
    end else if (grant_i) begin
      acc_ren   <= 1'b1;
      acc_wen   <= 1'b0;
      acc_addr  <= bus.iaddr;
      acc_store <= '0;
    end
  end

  assign busy         = (state != IDLE);
  assign bus.ramREN   = busy & acc_ren;
  assign bus.ramWEN   = busy & acc_wen;
  assign bus.ramaddr  = busy ? acc_addr  : '0;
  assign bus.ramstore = busy ? acc_store : '0;

  assign bus.iwait = bus.iREN && !((state == IACC) && bus.ramready);
  assign bus.dwait = dreq     && !((state == DACC) && bus.ramready);
  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int SM = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_MAX(SM)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: is an access in flight, whose, and what it is.
  bit          m_busy, m_d, m_wr;
  logic [31:0] m_addr, m_store;
  int          m_wait, m_starve;
  bit          m_done_i, m_done_d;
  byte         grants[$];
  logic [31:0] mem[logic [31:0]];
  int          ram_wait  = 0;
  bit          rand_wait = 0;
  bit          spur_en   = 0;
  bit          cmp_en    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_d = 0; m_wr = 0; m_addr = '0; m_store = '0;
    m_wait = 0; m_starve = 0;
    bus.ramready = 1'b0;
  endtask

  task automatic start_acc(input bit d, input bit wr, input logic [31:0] a, input logic [31:0] s);
    m_busy = 1; m_d = d; m_wr = wr; m_addr = a; m_store = s;
    m_wait = rand_wait ? int'($urandom_range(0, 3)) : ram_wait;
    grants.push_back(d ? "D" : "I");
  endtask

  // What the clock edge about to happen must do, from the arbitration rules.
  task automatic model_advance();
    bit dreq, forced;
    m_done_i = 0; m_done_d = 0;
    if (RST) begin
      model_reset();
      return;
    end
    if (m_busy) begin
      if (bus.ramready) begin
        if (m_wr) mem[m_addr] = m_store;
        m_busy = 0;
        if (m_d) m_done_d = 1; else m_done_i = 1;
      end
    end else begin
      dreq   = bus.dREN || bus.dWEN;
      forced = GUARD && (m_starve >= SM) && bus.iREN;
      if (dreq && !forced) begin
        start_acc(1, bus.dWEN, bus.daddr, bus.dstore);
        m_starve = bus.iREN ? ((m_starve < SM) ? m_starve + 1 : SM) : 0;
      end else if (bus.iREN) begin
        start_acc(0, 0, bus.iaddr, '0);
        m_starve = 0;
      end else begin
        m_starve = 0;
      end
    end
  endtask

  task automatic ram_drive();
    if (m_busy) begin
      if (m_wait == 0) begin
        bus.ramready = 1'b1;
        bus.ramload  = m_wr ? $urandom : rd(m_addr);
      end else begin
        m_wait--;
        bus.ramready = 1'b0;
        bus.ramload  = $urandom;
      end
    end else begin
      bus.ramready = spur_en && ($urandom_range(0, 5) == 0);
      bus.ramload  = $urandom;
    end
  endtask

  // Advance one clock; returns at posedge+1 with RAM inputs updated.
  task automatic tick();
    @(negedge CLK); #1;
    model_advance();
    @(posedge CLK); #1;
    ram_drive();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (m_busy && n < 50) begin tick(); n++; end
    checks++;
    if (m_busy) begin
      errors++;
      $display("FAIL %s: access still busy after 50 cycles, required idle", name);
    end
  endtask

  always @(negedge CLK) begin
    if (cmp_en) begin
      bit done;
      done = m_busy && bus.ramready;
      chk("ramREN", bus.ramREN, m_busy && !m_wr);
      chk("ramWEN", bus.ramWEN, m_busy && m_wr);
      chk("ramaddr", bus.ramaddr, m_busy ? m_addr : '0);
      if (!(m_busy && !m_d)) chk("ramstore", bus.ramstore, m_busy ? m_store : '0);
      chk("iwait", bus.iwait, bus.iREN && !(done && !m_d));
      chk("dwait", bus.dwait, (bus.dREN || bus.dWEN) && !(done && m_d));
      chk("iload", bus.iload, bus.ramload);
      chk("dload", bus.dload, bus.ramload);
    end
  end

  initial begin
    string exp_seq;
    int    n;
    RST = 1'b1;
    bus.iREN = 0; bus.iaddr = '0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramready = 0;
    model_reset();
    cmp_en = 1;

    // Reset state
    @(posedge CLK); #3;
    chk("rst_ramREN", bus.ramREN, 0);
    chk("rst_ramWEN", bus.ramWEN, 0);
    chk("rst_ramaddr", bus.ramaddr, 0);
    chk("rst_iwait_idle", bus.iwait, 0);
    bus.iREN = 1;
    #1 chk("rst_iwait_req", bus.iwait, 1);
    bus.iREN = 0;
    tick();
    RST = 1'b0;

    // Fetch only, 2-cycle RAM wait
    mem[32'h100] = 32'h8C220004;
    ram_wait = 2;
    bus.iREN = 1; bus.iaddr = 32'h100;
    #2 chk("f_pre_ramREN", bus.ramREN, 0);
    tick(); #2;
    chk("f_c1_ramREN", bus.ramREN, 1);
    chk("f_c1_ramaddr", bus.ramaddr, 32'h100);
    chk("f_c1_iwait", bus.iwait, 1);
    tick(); tick(); #2;
    chk("f_done_iwait", bus.iwait, 0);
    chk("f_done_iload", bus.iload, 32'h8C220004);
    tick(); bus.iREN = 0; #2;
    chk("f_idle_ramREN", bus.ramREN, 0);
    chk("f_idle_ramaddr", bus.ramaddr, 0);
    tick();

    // Simultaneous fetch and data read: data first, then fetch
    ram_wait = 1;
    grants.delete();
    bus.iREN = 1; bus.iaddr = 32'h300; bus.dREN = 1; bus.daddr = 32'h200;
    n = 0;
    while (n < 30) begin
      tick(); n++;
      if (m_done_d) bus.dREN = 0;
      if (m_done_i) begin bus.iREN = 0; break; end
    end
    chk("sim_grant_cnt", grants.size(), 2);
    if (grants.size() >= 2) begin
      chk("sim_grant0", grants[0], "D");
      chk("sim_grant1", grants[1], "I");
    end
    tick(); tick();

    // Continuous contention: grant order
    ram_wait = 0;
    grants.delete();
    bus.iREN = 1; bus.iaddr = 32'h400; bus.dREN = 1; bus.daddr = 32'h600;
    n = 0;
    while (grants.size() < 10 && n < 200) begin tick(); n++; end
    bus.iREN = 0; bus.dREN = 0;
    exp_seq = GUARD ? "DDDDIDDDDI" : "DDDDDDDDDD";
    chk("seq_len", grants.size() >= 10, 1);
    for (int k = 0; k < 10 && k < grants.size(); k++)
      chk($sformatf("seq_grant%0d", k), grants[k], exp_seq[k]);
    wait_idle("seq_drain");
    tick(); tick();

    // Write whose request drops mid-access
    ram_wait = 2;
    bus.dWEN = 1; bus.daddr = 32'h80; bus.dstore = 32'hDEADBEEF;
    tick();
    bus.dWEN = 0; bus.daddr = 32'h999; bus.dstore = '0;
    #2;
    chk("drop_ramWEN", bus.ramWEN, 1);
    chk("drop_ramaddr", bus.ramaddr, 32'h80);
    chk("drop_ramstore", bus.ramstore, 32'hDEADBEEF);
    wait_idle("drop_drain");
    for (int k = 0; k < 3; k++) begin
      tick(); #2 chk("drop_no_reissue", bus.ramWEN, 0);
    end

    // Read and write together: write wins
    ram_wait = 0;
    bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h500; bus.dstore = 32'h12345678;
    tick(); #2;
    chk("both_ramWEN", bus.ramWEN, 1);
    chk("both_ramREN", bus.ramREN, 0);
    bus.dREN = 0; bus.dWEN = 0;
    wait_idle("both_drain");
    tick();

    // Reset in the middle of a data write
    ram_wait = 3;
    bus.dWEN = 1; bus.daddr = 32'h40; bus.dstore = 32'h55AA55AA;
    tick(); #2 chk("rstmid_pre_ramWEN", bus.ramWEN, 1);
    RST = 1'b1; model_reset();
    #1;
    chk("rstmid_ramWEN", bus.ramWEN, 0);
    chk("rstmid_ramaddr", bus.ramaddr, 0);
    chk("rstmid_dwait", bus.dwait, 1);
    tick();
    RST = 1'b0;
    #2 chk("rstmid_rel_ramWEN", bus.ramWEN, 0);
    tick(); #2;
    chk("rstmid_regrant_ramWEN", bus.ramWEN, 1);
    chk("rstmid_regrant_ramaddr", bus.ramaddr, 32'h40);
    bus.dWEN = 0;
    wait_idle("rstmid_drain");
    tick();

    // Randomized traffic
    rand_wait = 1; spur_en = 1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (m_done_i && bus.iREN) begin
        if ($urandom_range(0, 1) == 0) bus.iREN = 0;
        else bus.iaddr = {$urandom_range(0, 255), 2'b00};
      end else if (!bus.iREN) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.iREN = 1; bus.iaddr = {$urandom_range(0, 255), 2'b00};
        end
      end else if ($urandom_range(0, 39) == 0) begin
        bus.iREN = 0;
      end
      if (m_done_d && (bus.dREN || bus.dWEN)) begin
        bus.dREN = 0; bus.dWEN = 0;
      end else if (!(bus.dREN || bus.dWEN)) begin
        if ($urandom_range(0, 2) == 0) begin
          n = $urandom_range(0, 9);
          bus.dREN   = (n <= 4) || (n == 9);
          bus.dWEN   = (n >= 5);
          bus.daddr  = {$urandom_range(0, 255), 2'b00};
          bus.dstore = $urandom;
        end
      end else if ($urandom_range(0, 39) == 0) begin
        bus.dREN = 0; bus.dWEN = 0;
      end
      if (RST) RST = 1'b0;
      else if ($urandom_range(0, 299) == 0) begin RST = 1'b1; model_reset(); end
    end

    bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0; RST = 1'b0;
    wait_idle("final_drain");
    tick();
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single unified RAM port between the instruction-fetch requester and the data requester of the single-cycle/pipelined CPU. It sits between the datapath's memory request lines (driven from the control unit's instruction-read, data-read and data-write enables) and the RAM model. A small FSM serialises accesses, stalls the losing requester through its wait line, and returns read data. Data accesses win by default, and an optional starvation guard bounds how long fetch can be starved.

## Interface
- STARVE_MAX, 4: consecutive data grants allowed while fetch is pending before fetch is forced; range 1..15.
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  1  instruction read request; held until iwait low.
- iaddr  in  32 (word_t)  fetch address.
- iwait  out  1  fetch stall.
- iload  out  32 (word_t)  fetched instruction, valid when iREN && !iwait.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32 (word_t)  data address.
- dstore  in  32 (word_t)  write data.
- dwait  out  1  data stall.
- dload  out  32 (word_t)  read data, valid when dREN && !dwait.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32 (word_t)  RAM address.
- ramstore  out  32 (word_t)  RAM write data.
- ramload  in  32 (word_t)  RAM read data, valid with ramready.
- ramready  in  1  one-cycle pulse: current RAM access complete.

## Operation
- States: IDLE, IACC, DACC.
- IDLE: if data request (dREN|dWEN) pending and guard not tripped → DACC; else if iREN → IACC; else stay.
- On entry to an ACC state, register the requester's address, store data and op (dWEN beats dREN if both are asserted; that combination is illegal but defined).
- IACC/DACC: drive ramREN/ramWEN, ramaddr and ramstore from the registered copies; hold until ramready, then go to IDLE.
- The mandatory IDLE cycle after each completion prevents a still-high request from being granted twice.
- iwait = iREN && !(state==IACC && ramready). dwait = (dREN|dWEN) && !(state==DACC && ramready).
- iload/dload = ramload, combinational pass-through (value is only meaningful in the completion cycle).
- Requester drops its request mid-access: the access still runs to ramready, the result is discarded, and the FSM returns to IDLE.
- Starve counter (4-bit): increments on each DACC grant made while iREN is high; clears on any IACC grant or when iREN is low in IDLE; saturates at STARVE_MAX.
- RAM outputs are 0 in IDLE.
- Reset (async, any state, mid-access included): state=IDLE, counter=0, ramREN=ramWEN=0, ramaddr=ramstore=0 and registered copies 0. iwait/dwait then follow their request inputs (high if requested). Any in-flight access is abandoned.

## Timing
- Grant is registered: a request seen in IDLE at edge N drives RAM strobes from cycle N+1.
- With a RAM that asserts ramready the same cycle (zero wait), minimum latency is 1 cycle of wait, then completion in the second cycle. Back-to-back throughput is one access per 2 cycles plus RAM wait cycles.
- With both requesters pending continuously and the guard enabled, the grant order is STARVE_MAX data accesses followed by 1 fetch, repeating.
- ramready outside IACC/DACC is ignored.

## Configuration
- ARB_STARVE_GUARD_EN defined: the starve counter is implemented. In IDLE with counter==STARVE_MAX and iREN high, IACC is granted even if data is pending.
- ARB_STARVE_GUARD_EN undefined: strict data priority. The counter is not implemented, STARVE_MAX is unused, and fetch waits until no data request is pending in IDLE.

## Test plan
- Reset mid-DACC write (daddr=0x40): assert RST → next sample shows ramWEN=0, ramaddr=0, state IDLE. Release → with dWEN still high, re-grant DACC one cycle later.
- Fetch only, iaddr=0x100, RAM with 2-cycle wait: ramREN=1 and ramaddr=0x100 from cycle 1. iwait drops in the ramready cycle with iload=ramload=0x8C220004. An IDLE cycle follows.
- Simultaneous iREN and dREN (daddr=0x200): DACC first, iwait stays high throughout. IACC is granted after the IDLE cycle once dREN drops.
- Guard enabled, STARVE_MAX=4, iREN and dREN held high continuously: grant sequence D,D,D,D,I,D,D,D,D,I. Guard disabled: fetch is never granted.
- dWEN drops mid-access (daddr=0x80, dstore=0xDEADBEEF): the write still completes on ramready with ramWEN held. FSM goes to IDLE and nothing is re-issued.
- dREN and dWEN both high: a write is issued (ramWEN=1, ramREN=0).
